apb_master_bridge: RTL

Upstream APB requester for the RISC-V data bus. Converts single load/store requests from the core's load-store unit into APB SETUP/ACCESS transfers, decodes the address onto one of two APB slaves (data memory, timer), honours PREADY wait states and returns read data or an error to the core. One transfer is in flight at a time.

---
 rtl/apb_master_bridge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
//==============================================================================
// apb_master_bridge: single-outstanding LSU request to two-slave APB bridge.
// Rev 1.0
//==============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter logic [31:0] MEM_BASE = 32'h0000_3000,
  parameter logic [31:0] MEM_LAST = 32'h0000_37FF,
  parameter logic [31:0] TMR_BASE = 32'h0000_4000,
  parameter logic [31:0] TMR_LAST = 32'h0000_401F,
  parameter int          TIMEOUT  = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL_MEM,
  output logic        PSEL_TMR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA_MEM,
  input  logic        PREADY_MEM,
  input  logic [31:0] PRDATA_TMR,
  input  logic        PREADY_TMR
);

  localparam int                 C_CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sel_tmr_q, sel_tmr_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               psel_mem_q, psel_mem_d;
  logic               psel_tmr_q, psel_tmr_d;
  logic               penable_q, penable_d;

  logic               w_hit_mem;
  logic               w_hit_tmr;
  logic               w_misaligned;
  logic               w_pready;
  logic [31:0]        w_prdata;

  assign w_hit_mem    = (req_addr >= MEM_BASE) && (req_addr <= MEM_LAST);
  assign w_hit_tmr    = (req_addr >= TMR_BASE) && (req_addr <= TMR_LAST);
  assign w_misaligned = (req_addr[1:0] != 2'b00);
  assign w_pready     = sel_tmr_q ? PREADY_TMR : PREADY_MEM;
  assign w_prdata     = sel_tmr_q ? PRDATA_TMR : PRDATA_MEM;

  always_comb begin
    state_d     = state_q;
    sel_tmr_d   = sel_tmr_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          if (w_misaligned || !(w_hit_mem || w_hit_tmr)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = 32'd0;
          end else begin
            state_d   = S_SETUP;
            sel_tmr_d = w_hit_tmr;
            cnt_d     = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_pready) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = pwrite_q ? 32'd0 : w_prdata;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
          // cnt_q counts earlier stalled cycles, so this is the TIMEOUT-th one
          if (cnt_q == C_CNT_LAST) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = 32'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered off the next state so they change on the edge.
    req_ready_d = (state_d == S_IDLE);
    penable_d   = (state_d == S_ACCESS);
    psel_mem_d  = !sel_tmr_d && ((state_d == S_SETUP) || (state_d == S_ACCESS));
    psel_tmr_d  =  sel_tmr_d && ((state_d == S_SETUP) || (state_d == S_ACCESS));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      sel_tmr_q   <= 1'b0;
      cnt_q       <= '0;
      paddr_q     <= 32'd0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      psel_mem_q  <= 1'b0;
      psel_tmr_q  <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_tmr_q   <= sel_tmr_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      psel_mem_q  <= psel_mem_d;
      psel_tmr_q  <= psel_tmr_d;
      penable_q   <= penable_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PSEL_MEM  = psel_mem_q;
  assign PSEL_TMR  = psel_tmr_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

`default_nettype wire
